// File: rtl/register_file_mp.sv
// Multi-ported register file: NREAD combinational reads, NWRITE clocked writes,
// optional same-cycle bypass, PC alias at the top index, and a busy scoreboard.
module register_file_mp #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int NREAD  = 3,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NWRITE-1:0]                   we,
  input  logic [NWRITE*$clog2(NREGS)-1:0]     wa,
  input  logic [NWRITE*DATA_W-1:0]            wd,
  input  logic [NREAD*$clog2(NREGS)-1:0]      ra,
  output logic [NREAD*DATA_W-1:0]             rd,
  input  logic [DATA_W-1:0]                   r15,
  input  logic                                alloc_en,
  input  logic [$clog2(NREGS)-1:0]            alloc_addr,
  output logic [NREGS-1:0]                    busy,
  output logic [NREAD-1:0]                    hazard
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] PC_IDX = AW'(NREGS - 1);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-2:0]  r_busy;

  logic [NREGS-1:0]  w_wr_hit;
  logic [DATA_W-1:0] w_wr_data [NREGS];
  logic [AW-1:0]     w_ra [NREAD];

  // Per-register write decode; later ports overwrite earlier ones, so the
  // highest-indexed port targeting a register wins.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    for (int i = 0; i < NREGS; i++) begin
      w_wr_hit[i]  = 1'b0;
      w_wr_data[i] = '0;
    end
    for (int p = 0; p < NWRITE; p++) begin
      for (int i = 0; i < NREGS; i++) begin
        if (we[p] && (wa[p*AW +: AW] == i[AW-1:0])) begin
          w_wr_hit[i]  = 1'b1;
          w_wr_data[i] = wd[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the array is reset explicitly because architectural state must read 0 after reset; it cannot map to a plain RAM.
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      // NOTE: non-blocking updates, so all ports and the scoreboard see pre-edge state.
      for (int i = 0; i < NREGS - 1; i++) begin
        if (w_wr_hit[i]) r_regs[i] <= w_wr_data[i];
      end
    end
  end

  // A new allocation outranks a same-cycle writeback: the newer producer is still pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NREGS - 1; i++) begin
        if (alloc_en && (alloc_addr == i[AW-1:0])) r_busy[i] <= 1'b1;
        else if (w_wr_hit[i])                      r_busy[i] <= 1'b0;
      end
    end
  end

  assign busy = {1'b0, r_busy};

  always_comb begin
    rd     = '0;
    hazard = '0;
    for (int k = 0; k < NREAD; k++) begin
      w_ra[k] = ra[k*AW +: AW];
      if (w_ra[k] == PC_IDX)
        rd[k*DATA_W +: DATA_W] = r15;
      else if ((BYPASS != 0) && !reset && w_wr_hit[w_ra[k]])
        rd[k*DATA_W +: DATA_W] = w_wr_data[w_ra[k]];
      else
        rd[k*DATA_W +: DATA_W] = r_regs[w_ra[k]];
      hazard[k] = busy[w_ra[k]] && !((BYPASS != 0) && w_wr_hit[w_ra[k]]);
    end
  end

endmodule
